lcd_cmd_writer: RTL and testbench

- Downstream bus stage for the LCD test logic: converts queued command/data bytes into HD44780-compliant write cycles on the 16x2 LCD's 8-bit bus.
- Drives LCD_EN, LCD_RS, LCD_RW and LCD_DATA directly; the upstream sequencer only pushes {RS, byte} through a valid/ready handshake.
- Contains a small FIFO so the upstream sequencer can issue bursts.
- Enforces per-instruction execution delay, including the long clear/home delay.

---
 rtl/lcd_cmd_writer.sv | 164 ++++++++++++++++
 tb/tb_lcd_cmd_writer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_writer.sv
// rtl/lcd_cmd_writer.sv - queued HD44780 8-bit bus write engine with per-entry execution delay
//
// Ports:
//   iCLK, iRST_N          clock, asynchronous active-low reset
//   iDATA, iRS, iValid    upstream entry {RS, byte}; accepted when iValid & oReady at a rising edge
//   oReady                FIFO has a free slot
//   oBusy                 write strobe or execution wait in progress
//   oIdle                 FIFO empty and no write in progress
//   LCD_DATA, LCD_RS      registered LCD bus value, stable for the whole write and wait
//   LCD_EN                registered enable strobe
//   LCD_RW                tied to write
module lcd_cmd_writer #(
    parameter int SETUP_CYC      = 2,
    parameter int EN_HIGH_CYC    = 16,
    parameter int HOLD_CYC       = 2,
    parameter int SHORT_WAIT_CYC = 2000,
    parameter int LONG_WAIT_CYC  = 82000,
    parameter int FIFO_AW        = 2
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic [7:0] iDATA,
    input  logic       iRS,
    input  logic       iValid,
    output logic       oReady,
    output logic       oBusy,
    output logic       oIdle,
    inout  wire  [7:0] LCD_DATA,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_RS
);
    localparam int DEPTH = 1 << FIFO_AW;
    // LONG_WAIT_CYC is the largest load value, so it sizes the shared down-counter.
    localparam int CW    = $clog2(LONG_WAIT_CYC + 1);

    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] EN_LD    = CW'(EN_HIGH_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] SHORT_LD = CW'(SHORT_WAIT_CYC - 1);
    localparam logic [CW-1:0] LONG_LD  = CW'(LONG_WAIT_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
    localparam logic [FIFO_AW:0]   CNT1     = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_EN_HI,
        S_HOLD,
        S_WAIT
    } state_t;

    state_t             state;
    logic [8:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic [8:0]         head;
    logic               push;
    logic               pop;
    logic [7:0]         data_q;
    logic               long_q;
    logic [CW-1:0]      cnt;

    assign oReady   = (count != FULL_CNT);
    assign push     = iValid & oReady;
    // Pop decision uses the registered count, so a fresh push is seen one edge later.
    assign pop      = (state == S_IDLE) && (count != '0);
    assign head     = mem[rd_ptr];

    assign oBusy    = (state != S_IDLE);
    assign oIdle    = (state == S_IDLE) && (count == '0);
    assign LCD_RW   = 1'b0;
    assign LCD_DATA = data_q;

    always_ff @(posedge iCLK) begin
        if (push) begin
            mem[wr_ptr] <= {iRS, iDATA};
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT1;
                2'b01:   count <= count - CNT1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state  <= S_IDLE;
            cnt    <= '0;
            data_q <= 8'h00;
            LCD_RS <= 1'b0;
            LCD_EN <= 1'b0;
            long_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        LCD_RS <= head[8];
                        data_q <= head[7:0];
                        // Clear display (0x01) and return home (0x02/0x03) need the long delay.
                        long_q <= ~head[8] && (head[7:2] == 6'd0) && (head[1:0] != 2'd0);
                        cnt    <= SETUP_LD;
                        state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt == '0) begin
                        LCD_EN <= 1'b1;
                        cnt    <= EN_LD;
                        state  <= S_EN_HI;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                S_EN_HI: begin
                    if (cnt == '0) begin
                        LCD_EN <= 1'b0;
                        cnt    <= HOLD_LD;
                        state  <= S_HOLD;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                S_HOLD: begin
                    if (cnt == '0) begin
                        cnt   <= long_q ? LONG_LD : SHORT_LD;
                        state <= S_WAIT;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    LCD_EN <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_cmd_writer.sv
// tb/tb_lcd_cmd_writer.sv - directed self-checking bench for lcd_cmd_writer
module tb_lcd_cmd_writer;
    localparam int SETUP = 2;
    localparam int ENH   = 16;
    localparam int HOLD  = 2;
    localparam int SW    = 20;
    localparam int LW    = 60;
    localparam int SP    = 1 + SETUP + ENH + HOLD + SW;   // 41
    localparam int LP    = 1 + SETUP + ENH + HOLD + LW;   // 81

    logic       iCLK = 1'b0;
    logic       iRST_N = 1'b0;
    logic [7:0] iDATA = 8'h00;
    logic       iRS = 1'b0;
    logic       iValid = 1'b0;
    logic       oReady, oBusy, oIdle;
    wire  [7:0] lcd_data;
    logic       LCD_RW, LCD_EN, LCD_RS;

    lcd_cmd_writer #(
        .SETUP_CYC(SETUP), .EN_HIGH_CYC(ENH), .HOLD_CYC(HOLD),
        .SHORT_WAIT_CYC(SW), .LONG_WAIT_CYC(LW), .FIFO_AW(2)
    ) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iDATA(iDATA), .iRS(iRS), .iValid(iValid),
        .oReady(oReady), .oBusy(oBusy), .oIdle(oIdle),
        .LCD_DATA(lcd_data), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN), .LCD_RS(LCD_RS)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    int         checks = 0;
    int         failures = 0;
    int         rise_q[$];
    logic [8:0] ent_q[$];
    int         width_q[$];
    int         rise_t = 0;
    int         stab_err = 0;
    logic       en_prev = 1'b0;
    logic [8:0] lat = '0;

    // Strobe monitor: records each EN rise (cycle, {RS,DATA}) and pulse width.
    always @(negedge iCLK) begin
        if (LCD_EN && !en_prev) begin
            rise_q.push_back(cyc);
            ent_q.push_back({LCD_RS, lcd_data});
            lat = {LCD_RS, lcd_data};
            rise_t = cyc;
        end else if (LCD_EN && ({LCD_RS, lcd_data} != lat)) begin
            stab_err++;
        end
        if (!LCD_EN && en_prev) width_q.push_back(cyc - rise_t);
        en_prev = LCD_EN;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        rise_q.delete();
        ent_q.delete();
        width_q.delete();
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge with iValid still high.
    task automatic push(input logic rs, input logic [7:0] d, output int acc);
        int n;
        n = 0;
        iRS = rs;
        iDATA = d;
        iValid = 1'b1;
        while (!oReady && n < 2000) begin
            @(negedge iCLK);
            n++;
        end
        check("push_ready_timeout", {31'd0, oReady}, 32'd1);
        acc = cyc + 1;
        @(negedge iCLK);
    endtask

    task automatic wait_idle(output int busy_cnt);
        int n;
        n = 0;
        busy_cnt = 0;
        while (!oIdle && n < 5000) begin
            if (oBusy) busy_cnt++;
            @(negedge iCLK);
            n++;
        end
        check("idle_timeout", {31'd0, oIdle}, 32'd1);
    endtask

    typedef struct {
        logic       rs;
        logic [7:0] d;
        logic       long_w;
    } wvec_t;

    wvec_t wv[6] = '{
        '{1'b0, 8'h01, 1'b1}, '{1'b0, 8'h02, 1'b1}, '{1'b0, 8'h03, 1'b1},
        '{1'b0, 8'h00, 1'b0}, '{1'b0, 8'h04, 1'b0}, '{1'b1, 8'h01, 1'b0}
    };

    initial begin
        int acc, acc2, b, n;

        // Reset state
        repeat (3) @(negedge iCLK);
        check("rst_en", {31'd0, LCD_EN}, 32'd0);
        check("rst_rs", {31'd0, LCD_RS}, 32'd0);
        check("rst_data", {24'd0, lcd_data}, 32'h00);
        check("rst_rw", {31'd0, LCD_RW}, 32'd0);
        check("rst_busy", {31'd0, oBusy}, 32'd0);
        check("rst_idle", {31'd0, oIdle}, 32'd1);
        check("rst_ready", {31'd0, oReady}, 32'd1);
        iRST_N = 1'b1;
        @(negedge iCLK);
        clear_mon();

        // Single command then data: latency, pulse width, stability, short period
        push(1'b0, 8'h38, acc);
        push(1'b1, 8'h41, acc2);
        iValid = 1'b0;
        wait_idle(b);
        check("t1_rises", rise_q.size(), 2);
        check("t1_latency", rise_q[0] - acc, 1 + SETUP);
        check("t1_width", width_q[0], ENH);
        check("t1_ent0", {23'd0, ent_q[0]}, 32'h038);
        check("t1_ent1", {23'd0, ent_q[1]}, 32'h141);
        check("t1_period", rise_q[1] - rise_q[0], SP);
        check("t1_busy_cycles", b, 2 * (SP - 1));
        check("t1_stable", stab_err, 0);

        // Wait class decode
        foreach (wv[i]) begin
            clear_mon();
            push(wv[i].rs, wv[i].d, acc);
            push(1'b1, 8'h41, acc2);
            iValid = 1'b0;
            wait_idle(b);
            check($sformatf("t2_rises_%0d", i), rise_q.size(), 2);
            check($sformatf("t2_ent_%0d", i), {23'd0, ent_q[0]}, {23'd0, wv[i].rs, wv[i].d});
            check($sformatf("t2_period_%0d", i), rise_q[1] - rise_q[0], wv[i].long_w ? LP : SP);
        end

        // FIFO full with iValid held high
        clear_mon();
        for (int i = 0; i < 5; i++) push(1'b1, 8'h30 + 8'(i), acc);
        check("t3_full_ready", {31'd0, oReady}, 32'd0);
        push(1'b1, 8'h35, acc);
        iValid = 1'b0;
        wait_idle(b);
        check("t3_rises", rise_q.size(), 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("t3_order_%0d", i), {23'd0, ent_q[i]}, 32'h130 + i);
        check("t3_ready_after_pop", acc - 1, rise_q[1] - SETUP);
        check("t3_stable", stab_err, 0);

        // Simultaneous push and pop with two entries queued
        clear_mon();
        push(1'b1, 8'h61, acc);
        push(1'b1, 8'h62, acc2);
        push(1'b1, 8'h63, acc2);
        iValid = 1'b0;
        n = 0;
        while (cyc < acc + SP && n < 200) begin
            @(negedge iCLK);
            n++;
        end
        push(1'b1, 8'h64, acc2);
        iValid = 1'b0;
        wait_idle(b);
        check("t4_rises", rise_q.size(), 4);
        check("t4_same_edge", acc2, rise_q[1] - SETUP);
        for (int i = 0; i < 4; i++)
            check($sformatf("t4_order_%0d", i), {23'd0, ent_q[i]}, 32'h161 + i);

        // Reset during the enable pulse with three entries queued
        clear_mon();
        for (int i = 0; i < 4; i++) push(1'b1, 8'h70 + 8'(i), acc);
        iValid = 1'b0;
        n = 0;
        while (!LCD_EN && n < 200) begin
            @(negedge iCLK);
            n++;
        end
        check("t5_en_seen", {31'd0, LCD_EN}, 32'd1);
        repeat (5) @(negedge iCLK);
        iRST_N = 1'b0;
        #1;
        check("t5_en_async", {31'd0, LCD_EN}, 32'd0);
        check("t5_idle", {31'd0, oIdle}, 32'd1);
        check("t5_ready", {31'd0, oReady}, 32'd1);
        check("t5_busy", {31'd0, oBusy}, 32'd0);
        repeat (2) @(negedge iCLK);
        iRST_N = 1'b1;
        @(negedge iCLK);
        clear_mon();
        repeat (3 * LP) @(negedge iCLK);
        check("t5_no_resume", rise_q.size(), 0);
        push(1'b1, 8'h55, acc);
        iValid = 1'b0;
        wait_idle(b);
        check("t5_new_rises", rise_q.size(), 1);
        check("t5_new_ent", {23'd0, ent_q[0]}, 32'h155);
        check("t5_new_width", width_q[0], ENH);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
